// File: rtl/frame_scanout_controller.sv
// frame_scanout_controller
//   Prefetches the next scanline from SRAM into one of two 160-word line
//   buffers. Each word packs 4 pixels of 4 bits. In parallel it reads the
//   buffer for the current scanline to produce a palette index. The fetch
//   engine owns SRAM only while EN is high. With EN low it freezes in place
//   and releases OE.
//
// Ports
//   Clk, Reset       : clock, synchronous active-high reset
//   EN               : SRAM access grant; fetch engine holds while low
//   even_frame       : display frame select, latched at each row-0 request
//   DrawX, DrawY     : VGA scan position (800x525 total, 640x480 visible)
//   pixel_index      : registered palette index, 1 Clk after DrawX/DrawY
//   step_done        : engine is at a point where SRAM may be handed off
//   line_done        : 1-cycle pulse after the last word of a line is stored
//   missed_line      : 1-cycle pulse when a line request is dropped
//   Data_to_SRAM     : never driven (high-Z); this block only reads
//   Data_from_SRAM   : SRAM read data
//   SRAM_WE_N/OE_N   : SRAM strobes (WE_N tied high)
//   SRAM_ADDRESS     : {1'b0, frame_sel, row[9:0], word[7:0]}

module frame_scanout_controller (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        EN,
   input  logic        even_frame,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [3:0]  pixel_index,
   output logic        step_done,
   output logic        line_done,
   output logic        missed_line,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic [19:0] SRAM_ADDRESS
);

   localparam int         WORDS     = 160;
   localparam logic [7:0] LAST_WORD = 8'd159;

   typedef enum logic [2:0] {IDLE, ADDR, WAIT_READ, WAIT_READ_2, READ} state_t;

   state_t      state;
   logic [7:0]  count;
   logic [9:0]  row;        // row being fetched; drives the address
   logic [9:0]  pend_row;   // row of the queued request
   logic        pending;
   logic        frame_sel;
   logic        oe_act;     // state wants OE; EN gates it onto the pin
   logic [9:0]  prev_y;

   logic [15:0] line_buf [2][WORDS];

   logic        req_valid;
   logic [9:0]  req_row;
   logic        visible;
   logic [15:0] rd_word;

   // prev_y is not reset. It keeps tracking DrawY, so leaving reset does not
   // manufacture a new-line request.
   always_ff @(posedge Clk) prev_y <= DrawY;

   // A new scanline requests the row after it. Line 524 is the last line of
   // the frame and prefetches row 0 of the next frame.
   always_comb begin
      req_valid = 1'b0;
      req_row   = '0;
      if (DrawY != prev_y) begin
         if (DrawY <= 10'd478) begin
            req_valid = 1'b1;
            req_row   = DrawY + 10'd1;
         end else if (DrawY == 10'd524) begin
            req_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= '0;
         row         <= '0;
         pend_row    <= '0;
         pending     <= 1'b0;
         frame_sel   <= 1'b0;
         line_done   <= 1'b0;
         missed_line <= 1'b0;
         step_done   <= 1'b1;
         oe_act      <= 1'b0;
      end else begin
         line_done   <= 1'b0;
         missed_line <= 1'b0;

         // Request capture runs regardless of EN. There is one slot only.
         // Frame select changes only when no fetch is queued or running, so
         // an in-flight line never switches frames.
         if (req_valid) begin
            if (pending || state != IDLE) begin
               missed_line <= 1'b1;
            end else begin
               pending  <= 1'b1;
               pend_row <= req_row;
               if (req_row == 10'd0) frame_sel <= even_frame;
            end
         end

         if (EN) begin
            unique case (state)
               IDLE: if (pending) begin
                  pending   <= 1'b0;
                  row       <= pend_row;
                  count     <= '0;
                  state     <= ADDR;
                  step_done <= 1'b1;
                  oe_act    <= 1'b0;
               end
               ADDR: begin
                  state     <= WAIT_READ;
                  step_done <= 1'b0;
                  oe_act    <= 1'b1;
               end
               WAIT_READ:   state <= WAIT_READ_2;
               WAIT_READ_2: state <= READ;
               READ: begin
                  step_done <= 1'b1;
                  oe_act    <= 1'b0;
                  if (count == LAST_WORD) begin
                     state     <= IDLE;
                     line_done <= 1'b1;
                  end else begin
                     count <= count + 8'd1;
                     state <= ADDR;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Buffer storage has no reset, so its contents are undefined after reset.
   always_ff @(posedge Clk) begin
      if (!Reset && EN && state == READ) line_buf[row[0]][count] <= Data_from_SRAM;
   end

   assign SRAM_ADDRESS = {1'b0, frame_sel, row, count};
   assign SRAM_OE_N    = ~(oe_act & EN);
   assign SRAM_WE_N    = 1'b1;
   assign Data_to_SRAM = 'z;

   // Display side, independent of EN. Writes always target row+1, which is
   // the other buffer, so the read never collides with a write.
   assign visible = (DrawX < 10'd640) && (DrawY < 10'd480);

   always_comb begin
      rd_word = '0;
      if (visible) rd_word = line_buf[DrawY[0]][DrawX[9:2]];
   end

   always_ff @(posedge Clk) begin
      if (Reset)        pixel_index <= '0;
      else if (visible) pixel_index <= rd_word[{DrawX[1:0], 2'b00} +: 4];
      else              pixel_index <= '0;
   end

endmodule

// File: tb/tb_frame_scanout_controller.sv
// Bench for frame_scanout_controller: SRAM behavioural model, line-buffer
// reference model and a monitor that records the fetch address stream.

module tb_frame_scanout_controller;

   logic        Clk = 1'b0;
   logic        Reset, en_set, tog_mode, EN, even_frame;
   logic [9:0]  DrawX, DrawY;
   logic [3:0]  pixel_index;
   logic        step_done, line_done, missed_line;
   wire  [15:0] data_to_sram;
   logic [15:0] data_from_sram;
   logic        sram_we_n, sram_oe_n;
   logic [19:0] sram_address;

   int          checks = 0, errors = 0;
   int          cyc = 0;
   logic [15:0] salt = 16'h0;
   logic [15:0] model_buf [2][160];

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   assign EN = tog_mode ? (((cyc / 3) % 2) == 1) : en_set;

   function automatic logic [15:0] mem_word(input logic [15:0] s, input logic fr,
                                            input logic [9:0] r, input logic [7:0] n);
      return 16'(n) + s * (16'(r) + (fr ? 16'd7 : 16'd0));
   endfunction

   assign data_from_sram = mem_word(salt, sram_address[18], sram_address[17:8], sram_address[7:0]);

   frame_scanout_controller dut (
      .Clk(Clk), .Reset(Reset), .EN(EN), .even_frame(even_frame),
      .DrawX(DrawX), .DrawY(DrawY), .pixel_index(pixel_index),
      .step_done(step_done), .line_done(line_done), .missed_line(missed_line),
      .Data_to_SRAM(data_to_sram), .Data_from_SRAM(data_from_sram),
      .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n), .SRAM_ADDRESS(sram_address)
   );

   // Expected buffer contents: the line buffer for row r is the SRAM words of
   // that row, in word order.
   task automatic fill_model(input logic fr, input int r);
      for (int n = 0; n < 160; n++) model_buf[r % 2][n] = mem_word(salt, fr, 10'(r), 8'(n));
   endtask

   function automatic logic [3:0] exp_pix(input int x, input int y);
      logic [15:0] w;
      if (x >= 640 || y >= 480) return 4'h0;
      w = model_buf[y % 2][x / 4];
      return 4'((w >> (4 * (x % 4))) & 16'hF);
   endfunction

   // Monitor. It counts enabled edges after the request edge, records
   // distinct addresses seen while OE is low, and counts rule violations.
   logic            mon_on = 1'b0;
   int unsigned     addr_q[$];
   int              en_edges, ld_cnt, miss_cnt, oe_cnt, oe_viol, hold_viol, we_viol;
   logic            en_last;
   logic [19:0]     last_addr;

   always @(Clk) begin
      if (Clk) begin
         en_last = EN;
         if (mon_on && EN && ld_cnt == 0) en_edges++;
      end else begin
         if (!mon_on) begin
            addr_q.delete();
            en_edges = 0; ld_cnt = 0; miss_cnt = 0; oe_cnt = 0;
            oe_viol = 0; hold_viol = 0; we_viol = 0;
         end else begin
            if (sram_we_n !== 1'b1) we_viol++;
            if (!EN && sram_oe_n !== 1'b1) oe_viol++;
            if (!en_last && addr_q.size() > 0 && ld_cnt == 0 && sram_address != last_addr) hold_viol++;
            if (sram_oe_n === 1'b0 && ld_cnt == 0) begin
               oe_cnt++;
               if (addr_q.size() == 0 || 32'(sram_address) != addr_q[$]) addr_q.push_back(32'(sram_address));
            end
            if (line_done) ld_cnt++;
            if (missed_line) miss_cnt++;
         end
         last_addr = sram_address;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   function automatic int addr_bad(input int unsigned base);
      if (addr_q.size() != 160) return 1000 + addr_q.size();
      for (int n = 0; n < 160; n++) if (addr_q[n] != base + n) return n + 1;
      return 0;
   endfunction

   // Restart the monitor and move DrawY. Counting starts on the edge after
   // the request edge.
   task automatic start_row(input int y);
      mon_on = 1'b0;
      @(negedge Clk);
      tick(1);
      DrawY = 10'(y);
      tick(1);
      mon_on = 1'b1;
   endtask

   task automatic begin_fetch524();
      DrawY = 10'd500;
      tick(2);
      start_row(524);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (ld_cnt == 0 && k < 4000) begin @(negedge Clk); k++; end
      checks++;
      if (ld_cnt == 0) begin errors++; $display("FAIL %s_timeout: line_done not seen in %0d cycles", name, k); end
      tick(1);
   endtask

   task automatic do_reset();
      Reset = 1'b1; en_set = 1'b1; tog_mode = 1'b0;
      DrawX = 10'd0; DrawY = 10'd0; even_frame = 1'b0;
      tick(3);
      Reset = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      Reset = 1'b1; en_set = 1'b1; tog_mode = 1'b0; even_frame = 1'b1;
      DrawX = 10'd5; DrawY = 10'd0;
      tick(3);
      checks++; if (pixel_index !== 4'h0) begin errors++; $display("FAIL rst_pix: got %0h want 0", pixel_index); end
      checks++; if (step_done !== 1'b1) begin errors++; $display("FAIL rst_step: got %b want 1", step_done); end
      checks++; if (line_done !== 1'b0 || missed_line !== 1'b0) begin errors++; $display("FAIL rst_pulses: got ld=%b ml=%b want 0", line_done, missed_line); end
      checks++; if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin errors++; $display("FAIL rst_strobes: got oe=%b we=%b want 1", sram_oe_n, sram_we_n); end
      checks++; if (sram_address !== 20'h0) begin errors++; $display("FAIL rst_addr: got %05h want 00000", sram_address); end
      Reset = 1'b0;
      tick(1);
   endtask

   task automatic test_fetch_row0();
      int b;
      do_reset();
      salt = 16'($urandom);
      even_frame = 1'b1;
      begin_fetch524();
      wait_done("row0");
      b = addr_bad(32'h40000);
      checks++; if (b != 0) begin errors++; $display("FAIL row0_addrs: bad index code %0d (n=%0d first=%05h) want 0x40000+n", b, addr_q.size(), addr_q.size() ? addr_q[0] : 0); end
      checks++; if (en_edges != 641) begin errors++; $display("FAIL row0_cycles: got %0d enabled edges want 641", en_edges); end
      checks++; if (oe_cnt != 480) begin errors++; $display("FAIL row0_oe: got %0d oe cycles want 480", oe_cnt); end
      tick(20);
      checks++; if (ld_cnt != 1 || miss_cnt != 0 || we_viol != 0) begin errors++; $display("FAIL row0_pulses: got ld=%0d miss=%0d we=%0d want 1 0 0", ld_cnt, miss_cnt, we_viol); end
      fill_model(1'b1, 0);
      DrawY = 10'd0;   // display row 0 while row 1 is being fetched
      for (int i = 0; i < 24; i++) begin
         DrawX = 10'($urandom_range(0, 799));
         tick(1);
         checks++;
         if (pixel_index !== exp_pix(int'(DrawX), 0)) begin
            errors++; $display("FAIL row0_pix x=%0d: got %0h want %0h", DrawX, pixel_index, exp_pix(int'(DrawX), 0));
         end
      end
   endtask

   task automatic test_pixel_row1();
      logic fe;
      do_reset();
      salt = 16'h0;
      fe = 1'($urandom);
      even_frame = fe;
      begin_fetch524();
      wait_done("p_row0");
      even_frame = ~fe;   // must not affect rows after row 0
      start_row(0);
      wait_done("p_row1");
      checks++; if (addr_bad({fe, 18'h0} | 32'h100) != 0) begin errors++; $display("FAIL row1_addrs: code %0d want frame %0b row 1", addr_bad({fe, 18'h0} | 32'h100), fe); end
      fill_model(fe, 1);
      DrawX = 10'd700; DrawY = 10'd1;
      tick(1);
      checks++; if (pixel_index !== 4'h0) begin errors++; $display("FAIL pix_x700: got %0h want 0", pixel_index); end
      DrawX = 10'd8;
      #1;
      checks++; if (pixel_index !== 4'h0) begin errors++; $display("FAIL pix_latency: got %0h want 0 before edge", pixel_index); end
      tick(1);
      checks++; if (pixel_index !== 4'h2) begin errors++; $display("FAIL pix_x8: got %0h want 2", pixel_index); end
      for (int i = 0; i < 16; i++) begin
         DrawX = 10'($urandom_range(0, 639));
         tick(1);
         checks++;
         if (pixel_index !== exp_pix(int'(DrawX), 1)) begin
            errors++; $display("FAIL row1_pix x=%0d: got %0h want %0h", DrawX, pixel_index, exp_pix(int'(DrawX), 1));
         end
      end
      DrawX = 10'd100; DrawY = 10'd500;
      tick(1);
      checks++; if (pixel_index !== 4'h0) begin errors++; $display("FAIL pix_y500: got %0h want 0", pixel_index); end
   endtask

   task automatic test_en_toggle();
      do_reset();
      salt = 16'($urandom);
      even_frame = 1'b1;
      tog_mode = 1'b1;
      begin_fetch524();
      wait_done("tog");
      checks++; if (addr_bad(32'h40000) != 0) begin errors++; $display("FAIL tog_addrs: code %0d want 0x40000+n", addr_bad(32'h40000)); end
      checks++; if (en_edges != 641) begin errors++; $display("FAIL tog_cycles: got %0d enabled edges want 641", en_edges); end
      checks++; if (oe_viol != 0 || hold_viol != 0) begin errors++; $display("FAIL tog_freeze: got oe_viol=%0d hold_viol=%0d want 0", oe_viol, hold_viol); end
      checks++; if (oe_cnt != 480) begin errors++; $display("FAIL tog_oe: got %0d oe cycles want 480", oe_cnt); end
      fill_model(1'b1, 0);
      DrawY = 10'd0;
      for (int i = 0; i < 16; i++) begin
         DrawX = 10'($urandom_range(0, 639));
         tick(1);
         checks++;
         if (pixel_index !== exp_pix(int'(DrawX), 0)) begin
            errors++; $display("FAIL tog_pix x=%0d: got %0h want %0h", DrawX, pixel_index, exp_pix(int'(DrawX), 0));
         end
      end
      tog_mode = 1'b0;
   endtask

   task automatic test_missed();
      do_reset();
      salt = 16'($urandom);
      even_frame = 1'b0;
      begin_fetch524();
      tick(20);
      DrawY = 10'd5;
      tick(1);
      checks++; if (missed_line !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b want 1", missed_line); end
      tick(1);
      checks++; if (missed_line !== 1'b0) begin errors++; $display("FAIL miss_width: got %b want 0", missed_line); end
      wait_done("miss");
      checks++; if (addr_bad(32'h0) != 0) begin errors++; $display("FAIL miss_addrs: code %0d want row 0", addr_bad(32'h0)); end
      tick(700);
      checks++; if (ld_cnt != 1 || miss_cnt != 1) begin errors++; $display("FAIL miss_counts: got ld=%0d miss=%0d want 1 1", ld_cnt, miss_cnt); end
      // Request while a previous one is still pending with EN low
      en_set = 1'b0;
      start_row(10);
      DrawY = 10'd11;
      tick(1);
      checks++; if (missed_line !== 1'b1) begin errors++; $display("FAIL pend_miss: got %b want 1", missed_line); end
      tick(4);
      en_set = 1'b1;
      wait_done("pend");
      checks++; if (addr_bad(32'h00B00) != 0) begin errors++; $display("FAIL pend_addrs: code %0d want row 11", addr_bad(32'h00B00)); end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      logic fe;
      do_reset();
      salt = 16'($urandom);
      fe = 1'($urandom);
      even_frame = fe;
      begin_fetch524();
      while (addr_q.size() < 51 && k < 2000) begin @(negedge Clk); k++; end
      checks++; if (addr_q.size() < 51) begin errors++; $display("FAIL rmid_reach: got %0d words want 51", addr_q.size()); end
      @(posedge Clk); #2;
      Reset = 1'b1;
      @(posedge Clk); #2;
      Reset = 1'b0;
      @(negedge Clk);
      checks++; if (step_done !== 1'b1 || sram_oe_n !== 1'b1 || line_done !== 1'b0) begin
         errors++; $display("FAIL rmid_idle: got step=%b oe=%b ld=%b want 1 1 0", step_done, sram_oe_n, line_done);
      end
      tick(800);
      checks++; if (ld_cnt != 0) begin errors++; $display("FAIL rmid_no_done: got %0d line_done want 0", ld_cnt); end
      begin_fetch524();
      wait_done("rmid");
      checks++; if (addr_bad({fe, 18'h0}) != 0) begin errors++; $display("FAIL rmid_restart: code %0d want word 0 onward", addr_bad({fe, 18'h0})); end
   endtask

   initial begin
      Reset = 1'b1; en_set = 1'b1; tog_mode = 1'b0; even_frame = 1'b0;
      DrawX = '0; DrawY = '0;
      test_reset();
      test_fetch_row0();
      test_pixel_row1();
      test_en_toggle();
      test_missed();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
